// File: rtl/flash_light_driver.sv
// Light driver: holds the F1/F2 one-hot flash speeds, runs the flash timebase and
// registers the light output. Define FLASH_SPEED_WRAP_EN to wrap speed shifts at the ends.
module flash_light_driver #(
  parameter int BASE_LOG2    = 22,
  parameter int SPEED_LEVELS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [5:0]              state,
  input  logic                    f1_shift_left,
  input  logic                    f1_shift_right,
  input  logic                    f2_shift_left,
  input  logic                    f2_shift_right,
  output logic                    light,
  output logic [SPEED_LEVELS-1:0] f1_speed,
  output logic [SPEED_LEVELS-1:0] f2_speed
);

  localparam int CW = BASE_LOG2 + SPEED_LEVELS;
  localparam logic [SPEED_LEVELS-1:0] SPEED_RST = SPEED_LEVELS'(1) << (SPEED_LEVELS / 2);

  typedef enum logic [5:0] {
    ST_OFF1 = 6'b000001,
    ST_ON   = 6'b000010,
    ST_OFF2 = 6'b000100,
    ST_F1   = 6'b001000,
    ST_OFF3 = 6'b010000,
    ST_F2   = 6'b100000
  } seq_state_e;

  function automatic logic [SPEED_LEVELS-1:0] shift_speed(
    input logic [SPEED_LEVELS-1:0] spd,
    input logic                    left,
    input logic                    right
  );
    logic [SPEED_LEVELS-1:0] res;
    res = spd;
    if (left && !right) begin
`ifdef FLASH_SPEED_WRAP_EN
      res = {spd[SPEED_LEVELS-2:0], spd[SPEED_LEVELS-1]};
`else
      if (!spd[SPEED_LEVELS-1]) res = {spd[SPEED_LEVELS-2:0], 1'b0};
`endif
    end else if (right && !left) begin
`ifdef FLASH_SPEED_WRAP_EN
      res = {spd[0], spd[SPEED_LEVELS-1:1]};
`else
      if (!spd[0]) res = {1'b0, spd[SPEED_LEVELS-1:1]};
`endif
    end
    return res;
  endfunction

  logic [5:0]              prev_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    phase_q, phase_d;
  logic                    light_q, light_d;
  logic [SPEED_LEVELS-1:0] f1_q, f1_d, f2_q, f2_d;

  logic                    is_f1, is_f2, flashing, entry;
  logic [SPEED_LEVELS-1:0] active_spd;
  logic [CW-1:0]           half_m1;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    is_f1      = (state == ST_F1);
    is_f2      = (state == ST_F2);
    flashing   = is_f1 || is_f2;
    entry      = (state != prev_q);
    active_spd = is_f2 ? f2_q : f1_q;

    half_m1 = '0;
    for (int i = 0; i < SPEED_LEVELS; i++) begin
      if (active_spd[i]) half_m1 = half_m1 | ((CW'(1) << (BASE_LOG2 + i)) - CW'(1));
    end

    f1_d = is_f1 ? shift_speed(f1_q, f1_shift_left, f1_shift_right) : f1_q;
    f2_d = is_f2 ? shift_speed(f2_q, f2_shift_left, f2_shift_right) : f2_q;

    cnt_d   = '0;
    phase_d = 1'b0;
    if (flashing) begin
      if (entry) begin
        phase_d = 1'b1;
      end else if (cnt_q >= half_m1) begin
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + CW'(1);
        phase_d = phase_q;
      end
    end

    // Light follows the phase being written this edge, so entry shows 1 immediately.
    light_d = flashing ? phase_d : (state == ST_ON);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      light_q <= 1'b0;
      f1_q    <= SPEED_RST;
      f2_q    <= SPEED_RST;
    end else begin
      prev_q  <= state;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      light_q <= light_d;
      f1_q    <= f1_d;
      f2_q    <= f2_d;
    end
  end

  assign light    = light_q;
  assign f1_speed = f1_q;
  assign f2_speed = f2_q;

endmodule

// File: tb/tb_flash_light_driver.sv
// Self-checking bench for flash_light_driver (BASE_LOG2=2, SPEED_LEVELS=3): vector table
// plus hand-written flash sequences, expectations queued per cycle and compared after the edge.
module tb_flash_light_driver;

  localparam logic [5:0] OFF1 = 6'b000001, ON = 6'b000010, OFF2 = 6'b000100;
  localparam logic [5:0] F1 = 6'b001000, OFF3 = 6'b010000, F2 = 6'b100000;
  // Strobe encoding {f1_left, f1_right, f2_left, f2_right}
  localparam logic [3:0] NONE = 4'b0000, F1L = 4'b1000, F1R = 4'b0100, F2L = 4'b0010, F2R = 4'b0001;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] state;
  logic       f1l, f1r, f2l, f2r;
  logic       light;
  logic [2:0] f1_speed, f2_speed;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       light;
    logic [2:0] f1;
    logic [2:0] f2;
    string      name;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [5:0] st;
    logic [3:0] strb;
    logic       light;
    logic [2:0] f1;
    logic [2:0] f2;
  } vec_t;
  vec_t vecs[15];

  flash_light_driver #(.BASE_LOG2(2), .SPEED_LEVELS(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .state         (state),
    .f1_shift_left (f1l),
    .f1_shift_right(f1r),
    .f2_shift_left (f2l),
    .f2_shift_right(f2r),
    .light         (light),
    .f1_speed      (f1_speed),
    .f2_speed      (f2_speed)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [5:0] st, input logic [3:0] strb, input logic e_l,
                      input logic [2:0] e1, input logic [2:0] e2, input string nm);
    exp_t e;
    state = st;
    {f1l, f1r, f2l, f2r} = strb;
    e.light = e_l;
    e.f1    = e1;
    e.f2    = e2;
    e.name  = nm;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb_q.pop_front();
      check({e.name, ".light"}, 32'(light), 32'(e.light));
      check({e.name, ".f1"}, 32'(f1_speed), 32'(e.f1));
      check({e.name, ".f2"}, 32'(f2_speed), 32'(e.f2));
    end
  endtask

  initial begin
    vecs[0]  = '{ON,       NONE,      1'b1, 3'b010, 3'b010};
    vecs[1]  = '{ON,       NONE,      1'b1, 3'b010, 3'b010};
    vecs[2]  = '{ON,       NONE,      1'b1, 3'b010, 3'b010};
    vecs[3]  = '{ON,       NONE,      1'b1, 3'b010, 3'b010};
    vecs[4]  = '{ON,       NONE,      1'b1, 3'b010, 3'b010};
    vecs[5]  = '{ON,       F1L | F2R, 1'b1, 3'b010, 3'b010};
    vecs[6]  = '{OFF2,     F1L | F2L, 1'b0, 3'b010, 3'b010};
    vecs[7]  = '{OFF1,     F1R,       1'b0, 3'b010, 3'b010};
    vecs[8]  = '{OFF3,     F2R,       1'b0, 3'b010, 3'b010};
    vecs[9]  = '{6'b000011, NONE,     1'b0, 3'b010, 3'b010};
    vecs[10] = '{6'b000000, NONE,     1'b0, 3'b010, 3'b010};
    vecs[11] = '{F2,       F1R,       1'b1, 3'b010, 3'b010};
    vecs[12] = '{F1,       F1L | F1R, 1'b1, 3'b010, 3'b010};
    vecs[13] = '{F1,       F2L,       1'b1, 3'b010, 3'b010};
    vecs[14] = '{OFF1,     NONE,      1'b0, 3'b010, 3'b010};

    reset = 1'b1;
    state = ON;
    {f1l, f1r, f2l, f2r} = NONE;
    #1;
    check("rst.light", 32'(light), 32'(1'b0));
    check("rst.f1", 32'(f1_speed), 32'(3'b010));
    check("rst.f2", 32'(f2_speed), 32'(3'b010));
    @(posedge clk);
    #1;
    check("rst_edge.light", 32'(light), 32'(1'b0));
    reset = 1'b0;

    for (int i = 0; i < 15; i++)
      step(vecs[i].st, vecs[i].strb, vecs[i].light, vecs[i].f1, vecs[i].f2, $sformatf("vec[%0d]", i));

    // F1 at default speed: H=8
    for (int k = 0; k < 24; k++)
      step(F1, NONE, ((k / 8) % 2) == 0, 3'b010, 3'b010, $sformatf("f1_h8[%0d]", k));

    // Four right pulses: 010 -> 001 then saturates, H=4
    step(OFF1, NONE, 1'b0, 3'b010, 3'b010, "pre_sat");
    for (int k = 0; k < 12; k++)
      step(F1, (k < 4) ? F1R : NONE, ((k / 4) % 2) == 0, 3'b001, 3'b010, $sformatf("f1_sat[%0d]", k));

    // F2 slower: 100, H=16; F1 untouched
    step(OFF2, NONE, 1'b0, 3'b001, 3'b010, "pre_f2");
    for (int k = 0; k < 20; k++)
      step(F2, (k == 0) ? F2L : NONE, k < 16, 3'b001, 3'b100, $sformatf("f2_h16[%0d]", k));

    // Mid-flash speed-up: H=8 until counter reaches 6, then H=4 forces an early toggle
    step(OFF3, NONE, 1'b0, 3'b001, 3'b100, "pre_mid");
    for (int k = 0; k < 13; k++) begin
      logic [3:0] s;
      logic       l;
      s = (k == 0) ? F1L : ((k == 6) ? F1R : NONE);
      l = (k <= 6) || (k >= 11);
      step(F1, s, l, (k < 6) ? 3'b010 : 3'b001, 3'b100, $sformatf("f1_mid[%0d]", k));
    end

    // Asynchronous reset between edges while light is high
    #2;
    reset = 1'b1;
    #1;
    check("async_rst.light", 32'(light), 32'(1'b0));
    check("async_rst.f1", 32'(f1_speed), 32'(3'b010));
    check("async_rst.f2", 32'(f2_speed), 32'(3'b010));
    state = 6'b000011;
    @(posedge clk);
    #1;
    check("held_rst.light", 32'(light), 32'(1'b0));
    reset = 1'b0;
    step(6'b000011, NONE, 1'b0, 3'b010, 3'b010, "post_rst_bad");
    step(F1, NONE, 1'b1, 3'b010, 3'b010, "post_rst_f1[0]");
    step(F1, NONE, 1'b1, 3'b010, 3'b010, "post_rst_f1[1]");

    // Reset with F1 held: first edge after release is an entry
    reset = 1'b1;
    #2;
    check("rst_f1.light", 32'(light), 32'(1'b0));
    reset = 1'b0;
    for (int k = 0; k < 10; k++)
      step(F1, NONE, k < 8, 3'b010, 3'b010, $sformatf("rst_f1_entry[%0d]", k));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
